// File: rtl/servo_pkg.sv
// -----------------------------------------------------------------------------
// servo_pkg
// Shared defaults and helper functions for the servo array.
// Holds the default parameter values, the cycles-per-microsecond derivation
// and the width helpers used to size counters in servo_array and
// servo_channel.
// -----------------------------------------------------------------------------
package servo_pkg;

    localparam int DEF_NUM_CH       = 3;
    localparam int DEF_CLK_HZ       = 50_000_000;
    localparam int DEF_FRAME_US     = 20000;
    localparam int DEF_MIN_US       = 1000;
    localparam int DEF_MAX_US       = 2000;
    localparam int DEF_STEP_US      = 10;
    localparam int DEF_DEBOUNCE_CYC = 500_000;

    localparam int US_PER_SEC = 1_000_000;

    // Number of clock cycles in one microsecond.
    function automatic int cyc_per_us(input int clk_hz);
        return clk_hz / US_PER_SEC;
    endfunction

    // Width of the microsecond counters (frame position and pulse width).
    function automatic int us_width(input int frame_us);
        return (frame_us <= 2) ? 1 : $clog2(frame_us);
    endfunction

    // Width of a counter that must be able to hold the value n.
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/servo_channel.sv
// -----------------------------------------------------------------------------
// servo_channel
// One servo channel: synchronises and debounces its push-button, toggles the
// commanded position on each accepted press, slews the pulse width toward
// the commanded target once per frame and generates the registered PWM drive.
//
// Ports
//   mclk       : clock, rising edge
//   rst        : asynchronous active-high reset
//   toggle     : raw asynchronous push-button input
//   frame_us   : shared position within the PWM frame, in microseconds
//   frame_wrap : one-cycle strobe on the tick where frame_us wraps to 0
//   led        : commanded position (0 = MIN_US, 1 = MAX_US)
//   servo      : registered PWM output
//   busy       : registered, high while the pulse width differs from target
// -----------------------------------------------------------------------------
module servo_channel
    import servo_pkg::*;
#(
    parameter int MIN_US       = DEF_MIN_US,
    parameter int MAX_US       = DEF_MAX_US,
    parameter int STEP_US      = DEF_STEP_US,
    parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
    parameter int UW           = us_width(DEF_FRAME_US)
) (
    input  logic          mclk,
    input  logic          rst,
    input  logic          toggle,
    input  logic [UW-1:0] frame_us,
    input  logic          frame_wrap,
    output logic          led,
    output logic          servo,
    output logic          busy
);

    localparam int DW = cnt_width(DEBOUNCE_CYC);

    logic [1:0]    sync_ff;
    logic          sync_level;
    logic          deb_level;
    logic          deb_prev;
    logic [DW-1:0] deb_cnt;
    logic          press;
    logic          led_d;
    logic [UW-1:0] pos_us;
    logic [UW-1:0] pos_d;
    logic [UW-1:0] target;
    logic [UW-1:0] target_d;

    // Two-flop synchroniser: the raw button is asynchronous to mclk, so
    // nothing downstream looks at it before it has passed both flops.
    always_ff @(posedge mclk or posedge rst) begin
        if (rst) begin
            sync_ff <= 2'b00;
        end else begin
            sync_ff <= {sync_ff[0], toggle};
        end
    end

    assign sync_level = sync_ff[1];

    // Debouncer: count consecutive cycles where the synchronised level
    // disagrees with the accepted level. Any return to agreement clears
    // the count, so only an uninterrupted run of DEBOUNCE_CYC cycles is
    // accepted. deb_prev feeds the rising-edge detector.
    always_ff @(posedge mclk or posedge rst) begin
        if (rst) begin
            deb_level <= 1'b0;
            deb_prev  <= 1'b0;
            deb_cnt   <= '0;
        end else begin
            deb_prev <= deb_level;
            if (sync_level == deb_level) begin
                deb_cnt <= '0;
            end else if (deb_cnt == DW'(DEBOUNCE_CYC - 1)) begin
                deb_level <= sync_level;
                deb_cnt   <= '0;
            end else begin
                deb_cnt <= deb_cnt + 1'b1;
            end
        end
    end

    // A press is the cycle after the debounced level rose; releases are
    // ignored.
    assign press    = deb_level & ~deb_prev;
    assign led_d    = led ^ press;
    assign target   = led   ? UW'(MAX_US) : UW'(MIN_US);
    assign target_d = led_d ? UW'(MAX_US) : UW'(MIN_US);

    // Slew step toward the current target, evaluated only at the frame
    // boundary so a pulse never changes width mid-frame. The arithmetic is
    // done one bit wider so pos_us + STEP_US cannot wrap, and the result is
    // clamped onto the target instead of overshooting it. A reversed target
    // simply flips the direction from wherever pos_us currently is.
    always_comb begin
        logic [UW:0] pos_x;
        logic [UW:0] tgt_x;
        logic [UW:0] step_x;
        pos_d  = pos_us;
        pos_x  = {1'b0, pos_us};
        tgt_x  = {1'b0, target};
        step_x = (UW+1)'(STEP_US);
        if (frame_wrap) begin
            if (pos_x < tgt_x) begin
                if (pos_x + step_x >= tgt_x) begin
                    pos_d = target;
                end else begin
                    pos_d = pos_us + UW'(STEP_US);
                end
            end else if (pos_x > tgt_x) begin
                if (pos_x <= tgt_x + step_x) begin
                    pos_d = target;
                end else begin
                    pos_d = pos_us - UW'(STEP_US);
                end
            end
        end
    end

    // Channel state and registered outputs. busy is computed from the
    // next-state values so it is coherent with led and pos_us on every
    // cycle. The PWM compare uses the registered frame position and width,
    // so each frame produces exactly pos_us microseconds of high time.
    always_ff @(posedge mclk or posedge rst) begin
        if (rst) begin
            led    <= 1'b0;
            pos_us <= UW'(MIN_US);
            busy   <= 1'b0;
            servo  <= 1'b0;
        end else begin
            led    <= led_d;
            pos_us <= pos_d;
            busy   <= (pos_d != target_d);
            servo  <= (frame_us < pos_us);
        end
    end

endmodule

// File: rtl/servo_array.sv
// -----------------------------------------------------------------------------
// servo_array
// Array of NUM_CH independent push-button controlled servo channels sharing
// one microsecond tick and one PWM frame counter.
//
// Ports
//   mclk   : clock, rising edge
//   rst    : asynchronous active-high reset
//   toggle : raw push-button per channel, active high
//   led    : commanded position per channel (0 = MIN_US, 1 = MAX_US)
//   servo  : registered PWM drive per channel
//   busy   : per channel, high while the pulse width is still ramping
// -----------------------------------------------------------------------------
module servo_array
    import servo_pkg::*;
#(
    parameter int NUM_CH       = DEF_NUM_CH,
    parameter int CLK_HZ       = DEF_CLK_HZ,
    parameter int FRAME_US     = DEF_FRAME_US,
    parameter int MIN_US       = DEF_MIN_US,
    parameter int MAX_US       = DEF_MAX_US,
    parameter int STEP_US      = DEF_STEP_US,
    parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC
) (
    input  logic              mclk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] toggle,
    output logic [NUM_CH-1:0] led,
    output logic [NUM_CH-1:0] servo,
    output logic [NUM_CH-1:0] busy
);

    localparam int CYC_PER_US = cyc_per_us(CLK_HZ);
    localparam int UW         = us_width(FRAME_US);
    localparam int TW         = cnt_width(CYC_PER_US - 1);

    logic [TW-1:0] tick_cnt;
    logic          tick;
    logic [UW-1:0] frame_us;
    logic          frame_wrap;

    assign tick       = (tick_cnt == TW'(CYC_PER_US - 1));
    assign frame_wrap = tick && (frame_us == UW'(FRAME_US - 1));

    // Shared timebase: tick_cnt divides mclk down to a 1 us tick, and
    // frame_us counts ticks across one PWM frame. Reset restarts both, so a
    // fresh frame always begins right after reset is released.
    always_ff @(posedge mclk or posedge rst) begin
        if (rst) begin
            tick_cnt <= '0;
            frame_us <= '0;
        end else begin
            if (tick) begin
                tick_cnt <= '0;
                if (frame_wrap) begin
                    frame_us <= '0;
                end else begin
                    frame_us <= frame_us + 1'b1;
                end
            end else begin
                tick_cnt <= tick_cnt + 1'b1;
            end
        end
    end

    // One fully independent channel per servo.
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        servo_channel #(
            .MIN_US       (MIN_US),
            .MAX_US       (MAX_US),
            .STEP_US      (STEP_US),
            .DEBOUNCE_CYC (DEBOUNCE_CYC),
            .UW           (UW)
        ) u_ch (
            .mclk       (mclk),
            .rst        (rst),
            .toggle     (toggle[i]),
            .frame_us   (frame_us),
            .frame_wrap (frame_wrap),
            .led        (led[i]),
            .servo      (servo[i]),
            .busy       (busy[i])
        );
    end

endmodule

// File: tb/tb_servo_array.sv
// -----------------------------------------------------------------------------
// tb_servo_array
// Self-checking bench for servo_array. Each call of applyStimulus runs one
// full PWM frame, optionally pressing buttons mid-frame, and checks pulse
// widths, led/busy state and led change timing against a frame-level model.
// -----------------------------------------------------------------------------
module tb_servo_array;

    localparam int NUM_CH       = 3;
    localparam int CLK_HZ       = 2_000_000;
    localparam int FRAME_US     = 200;
    localparam int MIN_US       = 50;
    localparam int MAX_US       = 100;
    localparam int STEP_US      = 20;
    localparam int DEBOUNCE_CYC = 8;

    localparam int CPU       = CLK_HZ / 1_000_000;
    localparam int FRAME_CYC = FRAME_US * CPU;
    localparam int PRESS_AT  = 60;
    localparam int STATE_AT  = 300;
    // Press raised after edge PRESS_AT+1: two synchroniser flops, DEBOUNCE_CYC
    // differing cycles, then one cycle for the edge detector.
    localparam int LED_LAT   = PRESS_AT + 2 + DEBOUNCE_CYC + 1;

    logic              mclk = 1'b0;
    logic              rst;
    logic [NUM_CH-1:0] toggle;
    logic [NUM_CH-1:0] led;
    logic [NUM_CH-1:0] servo;
    logic [NUM_CH-1:0] busy;

    int n_compared   = 0;
    int n_mismatched = 0;

    int pos_m [NUM_CH];
    bit led_m [NUM_CH];

    always #5 mclk = ~mclk;

    servo_array #(
        .NUM_CH       (NUM_CH),
        .CLK_HZ       (CLK_HZ),
        .FRAME_US     (FRAME_US),
        .MIN_US       (MIN_US),
        .MAX_US       (MAX_US),
        .STEP_US      (STEP_US),
        .DEBOUNCE_CYC (DEBOUNCE_CYC)
    ) dut (
        .mclk   (mclk),
        .rst    (rst),
        .toggle (toggle),
        .led    (led),
        .servo  (servo),
        .busy   (busy)
    );

    // Single comparison point for the whole bench.
    task automatic checkOutput(input string tag, input int observed, input int expected);
        n_compared++;
        if (observed !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    function automatic int target_of(input bit l);
        return l ? MAX_US : MIN_US;
    endfunction

    // Frame-boundary slew rule: move by STEP_US, never past the target.
    function automatic int step_toward(input int p, input int t);
        if (p < t) return (p + STEP_US > t) ? t : p + STEP_US;
        if (p > t) return (p - STEP_US < t) ? t : p - STEP_US;
        return p;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NUM_CH; i++) begin
            pos_m[i] = MIN_US;
            led_m[i] = 1'b0;
        end
    endtask

    // Run one frame. Channels in mask get a button press of the given length
    // starting at frame cycle PRESS_AT. If rst_at >= 0 the reset is asserted
    // at that frame cycle and the frame is abandoned after checking it.
    task automatic applyStimulus(input logic [NUM_CH-1:0] mask,
                                 input int l0, input int l1, input int l2,
                                 input int rst_at);
        int len [NUM_CH];
        int hi  [NUM_CH];
        int chg [NUM_CH];
        bit acc [NUM_CH];
        logic [NUM_CH-1:0] prev;
        len = '{l0, l1, l2};
        for (int i = 0; i < NUM_CH; i++) begin
            hi[i]  = 0;
            chg[i] = -1;
            acc[i] = mask[i] && (len[i] >= DEBOUNCE_CYC);
            if (acc[i]) led_m[i] = !led_m[i];
        end
        prev = led;
        for (int c = 0; c < FRAME_CYC; c++) begin
            @(posedge mclk);
            #1;
            for (int i = 0; i < NUM_CH; i++)
                toggle[i] = mask[i] && (c >= PRESS_AT) && (c < PRESS_AT + len[i]);
            @(negedge mclk);
            for (int i = 0; i < NUM_CH; i++) begin
                if (servo[i]) hi[i]++;
                if ((led[i] != prev[i]) && (chg[i] < 0)) chg[i] = c;
            end
            prev = led;
            if (c == STATE_AT) begin
                for (int i = 0; i < NUM_CH; i++) begin
                    checkOutput($sformatf("led%0d", i), int'(led[i]), int'(led_m[i]));
                    checkOutput($sformatf("busy%0d", i), int'(busy[i]),
                                int'(pos_m[i] != target_of(led_m[i])));
                end
            end
            if (c == rst_at) begin
                rst = 1'b1;
                #1;
                checkOutput("rst_servo", int'(servo), 0);
                checkOutput("rst_led", int'(led), 0);
                checkOutput("rst_busy", int'(busy), 0);
                toggle = '0;
                repeat (3) @(negedge mclk);
                rst = 1'b0;
                model_reset();
                return;
            end
        end
        for (int i = 0; i < NUM_CH; i++) begin
            checkOutput($sformatf("pulse%0d", i), hi[i], pos_m[i] * CPU);
            checkOutput($sformatf("ledchg%0d", i), chg[i], acc[i] ? LED_LAT : -1);
            pos_m[i] = step_toward(pos_m[i], target_of(led_m[i]));
        end
    endtask

    initial begin
        int rl [NUM_CH];
        logic [NUM_CH-1:0] rmask;
        rst    = 1'b1;
        toggle = '0;
        model_reset();
        repeat (3) @(negedge mclk);
        checkOutput("init_servo", int'(servo), 0);
        checkOutput("init_led", int'(led), 0);
        checkOutput("init_busy", int'(busy), 0);
        rst = 1'b0;

        applyStimulus(3'b000, 0, 0, 0, -1);    // idle: MIN_US pulses
        applyStimulus(3'b001, 20, 0, 0, -1);   // ch0 press, ramp 50->100
        applyStimulus(3'b010, 0, 5, 0, -1);    // ch1 bounce too short
        applyStimulus(3'b100, 0, 0, 20, -1);   // ch2 press, ramp up
        applyStimulus(3'b100, 0, 0, 20, -1);   // ch2 reverse at 70 us
        applyStimulus(3'b111, 15, 15, 15, -1); // simultaneous presses
        applyStimulus(3'b001, 20, 0, 0, -1);   // led -> 111
        applyStimulus(3'b000, 0, 0, 0, -1);
        applyStimulus(3'b000, 0, 0, 0, 30);    // reset mid-pulse
        applyStimulus(3'b000, 0, 0, 0, -1);    // first post-reset frame

        for (int k = 0; k < 12; k++) begin
            rmask = NUM_CH'($urandom_range(0, 7));
            for (int i = 0; i < NUM_CH; i++)
                rl[i] = ($urandom_range(0, 1) == 1) ? int'($urandom_range(10, 30))
                                                     : int'($urandom_range(1, 6));
            applyStimulus(rmask, rl[0], rl[1], rl[2], -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/servo_array.md
SERVO_ARRAY -- requirements
Module: servo_array

Interface
REQ-001 SHALL have parameter NUM_CH, default 3: number of independent servo channels (1..16).
REQ-002 SHALL have parameter CLK_HZ, default 50_000_000: mclk frequency; CLK_HZ/1_000_000 (CYC_PER_US) SHALL be an integer ≥2.
REQ-003 SHALL have parameter FRAME_US, default 20000: PWM frame period in µs.
REQ-004 SHALL have parameter MIN_US, default 1000: pulse width for position 0.
REQ-005 SHALL have parameter MAX_US, default 2000: pulse width for position 1; MIN_US < MAX_US < FRAME_US.
REQ-006 SHALL have parameter STEP_US, default 10: maximum pulse-width change per frame (slew limit), ≥1.
REQ-007 SHALL have parameter DEBOUNCE_CYC, default 500_000: cycles a synchronised toggle level must stay stable before it is accepted.
REQ-008 SHALL have port mclk, input, 1: single clock, all logic rising-edge.
REQ-009 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-010 SHALL have port toggle, input, NUM_CH: asynchronous push-button per channel, active-high.
REQ-011 SHALL have port led, output, NUM_CH: current commanded position per channel (0=MIN, 1=MAX).
REQ-012 SHALL have port servo, output, NUM_CH: registered PWM drive per channel.
REQ-013 SHALL have port busy, output, NUM_CH: channel pulse width not yet equal to its target.

Function
REQ-014 SHALL pass each toggle bit through a 2-flop synchroniser before any other use.
REQ-015 SHALL accept a new debounced level only after the synchronised level differs from it for DEBOUNCE_CYC consecutive cycles; any intermediate change SHALL restart the count.
REQ-016 SHALL invert led[i] on the cycle after debounced level i rises 0->1; falling edges have no effect.
REQ-017 SHALL derive a shared 1 µs tick every CYC_PER_US cycles and a shared frame counter frame_us 0..FRAME_US-1 advancing on each tick, wrapping to 0.
REQ-018 SHALL hold target[i] = MAX_US when led[i]=1, else MIN_US, updated combinationally from led.
REQ-019 SHALL update pos_us[i] only on the tick where frame_us wraps FRAME_US-1->0: move toward target[i] by STEP_US, clamped to land exactly on target (no overshoot).
REQ-020 SHALL drive servo[i] high exactly while frame_us < pos_us[i], as a registered output, giving exactly pos_us[i]*CYC_PER_US high cycles per frame, starting at frame start.
REQ-021 SHALL never change a pulse width mid-frame; a toggle during a frame affects the next frame boundary only.
REQ-022 SHALL, on a toggle while ramping, reverse target immediately and ramp from the current pos_us without jumping.
REQ-023 SHALL assert busy[i] whenever pos_us[i] ≠ target[i], registered.
REQ-024 SHALL size pos_us and frame_us to $clog2(FRAME_US) bits, unsigned; ramp arithmetic SHALL not overflow at MAX_US+STEP_US.
REQ-025 SHALL process channels independently; simultaneous toggles on several channels SHALL all be honoured in the same cycle.

Reset
REQ-026 SHALL, on rst, asynchronously force: led=0, servo=0, busy=0, pos_us=MIN_US, tick and frame counters=0, debounced levels=0, synchroniser flops=0, debounce counters=0.
REQ-027 SHALL, after rst deasserts mid-frame, start a fresh frame from frame_us=0 with a MIN_US pulse.

Structure
REQ-028 SHALL place default parameters, CYC_PER_US derivation and width helper constants in package servo_pkg.
REQ-029 SHALL implement per-channel synchroniser, debouncer, led toggle, ramp and PWM compare in sub-module servo_channel, generated NUM_CH times; tick and frame counters live once in servo_array.

Verification (params: CLK_HZ=2_000_000, FRAME_US=200, MIN_US=50, MAX_US=100, STEP_US=20, DEBOUNCE_CYC=8, NUM_CH=3)
REQ-030 SHALL cover: release rst, no input -> every servo high 100 cycles per 400-cycle frame, led=000, busy=000.
REQ-031 SHALL cover: toggle[0] high 20 cycles -> led[0]=1, busy[0]=1; next frames pulse 140, 180, 200 cycles (50->70->90->100 µs), then busy[0]=0.
REQ-032 SHALL cover: toggle[1] high 5 cycles (< debounce) -> led[1] stays 0, servo[1] unchanged.
REQ-033 SHALL cover: toggle[2] pressed again while at 70 µs on the way up -> next frames 50 µs (clamped, 70-20), busy[2]=0 afterward.
REQ-034 SHALL cover: rst asserted mid-pulse with led=111 -> servo=000 and led=000 the same cycle; first post-reset frame pulse = 100 cycles on all channels.
REQ-035 SHALL cover: toggles on all 3 channels in the same cycle -> all led bits flip on the same cycle.
